// File: rtl/md_unit_pkg.sv
// ---------------------------------------------------------------------------
// md_unit_pkg
// Shared constants for the multiply/divide unit: MD op encodings, the FSM
// state encoding and a small decode helper used by both md_unit and md_calc.
// ---------------------------------------------------------------------------
package md_unit_pkg;

   localparam int MD_OP_W = 3;

   localparam logic [MD_OP_W-1:0] MD_NOP   = 3'd0;
   localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd1;
   localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd2;
   localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd3;
   localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd4;
   localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd5;
   localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd6;

   typedef enum logic {
      MD_ST_IDLE = 1'b0,
      MD_ST_RUN  = 1'b1
   } md_state_e;

   // True for the multi-cycle ops that occupy the unit and stall the front end.
   function automatic logic md_is_long(input logic [MD_OP_W-1:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   // Divides take DIV_LAT cycles, multiplies MUL_LAT.
   function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_calc.sv
// ---------------------------------------------------------------------------
// md_calc
// Purely combinational HI/LO result generator for the MD unit.
// Ports:
//   op        - MD operation code
//   a, b      - rs / rt operands
//   hi_res    - value destined for HI
//   lo_res    - value destined for LO
//   res_valid - result should be committed (0 for divide-by-zero and for
//               ops that do not produce a product/quotient)
// ---------------------------------------------------------------------------
module md_calc
   import md_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [MD_OP_W-1:0] op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [WIDTH-1:0]   hi_res,
   output logic [WIDTH-1:0]   lo_res,
   output logic               res_valid
);

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic signed [2*WIDTH-1:0] prod_s;
   logic        [2*WIDTH-1:0] prod_u;
   logic                      div_zero;
   logic                      div_ovf;
   logic        [WIDTH-1:0]   div_bs;
   logic        [WIDTH-1:0]   div_bu;
   logic        [WIDTH-1:0]   quot_s;
   logic        [WIDTH-1:0]   rem_s;
   logic        [WIDTH-1:0]   quot_u;
   logic        [WIDTH-1:0]   rem_u;

   // Arithmetic datapath. The divisors are substituted with 1 for the
   // divide-by-zero and most-negative/-1 cases: a zero divisor produces no
   // committed result anyway, and MOST_NEG/1 yields exactly the required
   // quotient MOST_NEG with remainder 0 without ever evaluating the
   // overflowing division.
   always_comb begin
      prod_s   = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
      prod_u   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      div_zero = (b == '0);
      div_ovf  = (a == MOST_NEG) && (b == '1);
      div_bs   = (div_zero || div_ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
      div_bu   = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
      quot_s   = $signed(a) / $signed(div_bs);
      rem_s    = $signed(a) % $signed(div_bs);
      quot_u   = a / div_bu;
      rem_u    = a % div_bu;
   end

   // Result select by op code.
   always_comb begin
      hi_res    = '0;
      lo_res    = '0;
      res_valid = 1'b0;
      case (op)
         MD_MULT: begin
            hi_res    = prod_s[2*WIDTH-1:WIDTH];
            lo_res    = prod_s[WIDTH-1:0];
            res_valid = 1'b1;
         end
         MD_MULTU: begin
            hi_res    = prod_u[2*WIDTH-1:WIDTH];
            lo_res    = prod_u[WIDTH-1:0];
            res_valid = 1'b1;
         end
         MD_DIV: begin
            hi_res    = rem_s;
            lo_res    = quot_s;
            res_valid = !div_zero;
         end
         MD_DIVU: begin
            hi_res    = rem_u;
            lo_res    = quot_u;
            res_valid = !div_zero;
         end
         default: begin
            res_valid = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit
// Multiply/divide unit beside the E-stage ALU. Owns the HI/LO registers,
// runs MULT/MULTU/DIV/DIVU over a fixed number of busy cycles and executes
// MTHI/MTLO in one cycle.
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset
//   start, op    - MD instruction in E this cycle and its op code
//   a, b         - forwarded rs / rt values
//   flush        - abort any in-flight op and drop this cycle's start
//   busy         - long op in flight
//   stall_req    - busy, or a long op being issued this cycle
//   hi, lo       - architectural HI / LO
// ---------------------------------------------------------------------------
module md_unit
   import md_unit_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [MD_OP_W-1:0] op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               flush,
   output logic               busy,
   output logic               stall_req,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo
);

   localparam logic [7:0] MUL_CNT = 8'(MUL_LAT);
   localparam logic [7:0] DIV_CNT = 8'(DIV_LAT);

   md_state_e        state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_pend_q, hi_pend_d;
   logic [WIDTH-1:0] lo_pend_q, lo_pend_d;
   logic             pend_valid_q, pend_valid_d;

   logic [WIDTH-1:0] calc_hi;
   logic [WIDTH-1:0] calc_lo;
   logic             calc_valid;

   md_calc #(
      .WIDTH (WIDTH)
   ) u_calc (
      .op        (op),
      .a         (a),
      .b         (b),
      .hi_res    (calc_hi),
      .lo_res    (calc_lo),
      .res_valid (calc_valid)
   );

   // State register: FSM state, busy counter, HI/LO and the pending result.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= MD_ST_IDLE;
         cnt_q        <= '0;
         hi_q         <= '0;
         lo_q         <= '0;
         hi_pend_q    <= '0;
         lo_pend_q    <= '0;
         pend_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         hi_pend_q    <= hi_pend_d;
         lo_pend_q    <= lo_pend_d;
         pend_valid_q <= pend_valid_d;
      end
   end

   // Next-state logic. Flush wins over everything, including the commit in
   // the last busy cycle. The result is computed at issue and parked in the
   // pending registers; pend_valid carries the divide-by-zero suppression
   // through to the commit edge.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      hi_pend_d    = hi_pend_q;
      lo_pend_d    = lo_pend_q;
      pend_valid_d = pend_valid_q;
      if (flush) begin
         state_d      = MD_ST_IDLE;
         cnt_d        = '0;
         hi_pend_d    = '0;
         lo_pend_d    = '0;
         pend_valid_d = 1'b0;
      end else begin
         case (state_q)
            MD_ST_IDLE: begin
               if (start) begin
                  if (md_is_long(op)) begin
                     hi_pend_d    = calc_hi;
                     lo_pend_d    = calc_lo;
                     pend_valid_d = calc_valid;
                     cnt_d        = md_is_div(op) ? DIV_CNT : MUL_CNT;
                     state_d      = MD_ST_RUN;
                  end else if (op == MD_MTHI) begin
                     hi_d = a;
                  end else if (op == MD_MTLO) begin
                     lo_d = a;
                  end
               end
            end
            MD_ST_RUN: begin
               cnt_d = cnt_q - 8'd1;
               if (cnt_q == 8'd1) begin
                  if (pend_valid_q) begin
                     hi_d = hi_pend_q;
                     lo_d = lo_pend_q;
                  end
                  pend_valid_d = 1'b0;
                  state_d      = MD_ST_IDLE;
               end
            end
            default: begin
               state_d = MD_ST_IDLE;
            end
         endcase
      end
   end

   // Outputs. stall_req covers the issue cycle combinationally so a
   // dependent MFHI/MFLO in D is held until the result lands.
   always_comb begin
      busy      = (state_q == MD_ST_RUN);
      stall_req = busy | (start & md_is_long(op));
      hi        = hi_q;
      lo        = lo_q;
   end

endmodule
